em_banked_ctrl: RTL and testbench
=================================

// Module: em_banked_ctrl
// PURPOSE
//  Parametrised byte-addressed external memory with a handshaked data port and a combinational
//  16-bit instruction-fetch port. After reset it copies a boot image from em_boot_rom into RAM.
//  Data access sizes are 1, 2 or 4 bytes, little-endian, with programmable wait states.
//  Sits between the core's load/store unit and fetch stage, replacing the fixed 49-byte memory.
// PARAMETERS
//  MEM_BYTES    64       RAM depth in bytes (valid addresses 0..MEM_BYTES-1)
//  ADDR_W       10       address width of d_addr / i_addr
//  WAIT_STATES  0        extra cycles between accept and commit (0..15)
//  INIT_BYTES   48       bytes copied from em_boot_rom at boot (<= MEM_BYTES)
//  NOP_INSTR    16'hE800 value returned on i_instr while booting or when the fetch is out of range
// PORTS
//  clock    in   1       system clock, rising edge
//  reset    in   1       asynchronous, active-high
//  d_req    in   1       data request; held with its fields until accepted
//  d_we     in   1       1 = write, 0 = read
//  d_size   in   2       1 = byte, 2 = halfword, 3 = word; 0 = illegal (flagged as error)
//  d_addr   in   ADDR_W  base byte address; bytes at d_addr .. d_addr+n-1
//  d_wdata  in   32      write data; lane i is written to d_addr+i
//  d_ready  out  1       high in IDLE; the request is accepted on an edge where d_req && d_ready
//  d_rvalid out  1       one-cycle completion pulse, for reads and writes
//  d_rdata  out  32      read data, zero-extended; valid with d_rvalid
//  d_err    out  1       with d_rvalid: access out of range or d_size==0
//  i_addr   in   ADDR_W  fetch address; returns bytes i_addr (low) and i_addr+1 (high)
//  i_instr  out  16      fetched halfword, combinational
//  busy     out  1       high while in the INIT state
// BEHAVIOUR
//  Reset values: d_ready=0, d_rvalid=0, d_rdata=0, d_err=0, busy=1, state=INIT, copy pointer=0.
//   RAM contents are not cleared by reset.
//  INIT state:
//   - Each cycle copies rom[ptr] to RAM[ptr] and increments ptr.
//   - After the copy at ptr==INIT_BYTES-1: next state IDLE, busy=0.
//   - INIT lasts exactly INIT_BYTES cycles. If INIT_BYTES==0, INIT lasts 1 cycle.
//   - Bytes at INIT_BYTES and above keep their previous contents.
//  IDLE state:
//   - d_ready=1.
//   - On accept: latch we/size/addr/wdata, load the wait counter with WAIT_STATES, go to BUSY.
//  BUSY state:
//   - d_ready=0. The counter decrements each cycle; the last BUSY cycle is the one with counter==0.
//   - Error check: n = 1/2/4 for d_size = 1/2/3; err = (size==0) || (addr+n-1 >= MEM_BYTES).
//     The sum addr+n-1 is computed at ADDR_W+1 bits, so there is no wrap-around.
//   - Commit edge, which ends the last BUSY cycle:
//     - If !err and write: write n bytes.
//     - If !err and read: d_rdata <= bytes (upper lanes 0).
//     - If err: no write, d_rdata <= 0.
//   - Then state RESP.
//  RESP state:
//   - d_rvalid=1 and d_err valid for this one cycle; next state IDLE.
//   - d_rdata holds its value until the next commit.
//  Latency: accept at edge k; d_rvalid is high in the cycle after edge k+WAIT_STATES+1.
//  Throughput: one access per WAIT_STATES+3 cycles.
//  Fetch port:
//   - If busy, or i_addr+1 >= MEM_BYTES: i_instr = NOP_INSTR.
//   - Otherwise i_instr = {RAM[i_addr+1], RAM[i_addr]}.
//   - Forwarding: in the last BUSY cycle of a valid write, any fetched byte whose address matches
//     a lane being written returns that lane's d_wdata byte. The lowest matching lane wins.
//  A request presented during INIT, BUSY or RESP is not accepted and must be held by the master.
//  Reset asserted mid-operation:
//   - Aborts immediately; any uncommitted write is lost; no d_rvalid is produced.
//   - INIT restarts from ptr 0.
// STRUCTURE
//  Shared package em_pkg:
//   - size codes EM_BYTE=1, EM_HALF=2, EM_WORD=3.
//   - state enum {INIT, IDLE, BUSY, RESP}.
//   - default NOP_INSTR constant.
//  Sub-module em_boot_rom:
//   - Combinational byte ROM (INIT_BYTES deep) holding the program image.
//   - Port: addr in, data out. Image is regenerated by the assembler flow.
//  The top level holds the FSM, wait counter, RAM array, range checks and fetch forwarding mux.
// TESTING
//  1. Reset, then hold for INIT_BYTES cycles: busy falls exactly after cycle 48; i_instr=16'hE800
//     during boot; afterwards i_addr=0 returns {rom[1], rom[0]}.
//  2. Word write 0xA1B2C3D4 to addr 20, then byte read of 21 -> d_rdata=0x000000C3; halfword read
//     of 22 -> 0x0000A1B2; d_err=0 throughout.
//  3. Out of range: word read at 62 (MEM_BYTES=64) -> d_rvalid with d_err=1, d_rdata=0. Write of
//     size 0 -> d_err=1 and RAM unchanged.
//  4. Forwarding: i_addr=30 held, halfword write 0xBEEF to 31. During the commit cycle i_instr
//     upper byte=0xEF; from the next cycle onward i_instr reads the committed RAM value.
//  5. WAIT_STATES=3: req at edge k -> d_rvalid in the cycle after edge k+4. d_ready is low for
//     5 cycles. A second req held during that time is accepted only once the block returns to IDLE.
//  6. Assert reset in the middle of a BUSY word write to 8: no d_rvalid; after re-boot RAM[8..11]
//     equals rom[8..11].

Source files
------------

// File: rtl/em_pkg.sv
// em_pkg: size codes, FSM states and defaults shared by the external memory slice.
package em_pkg;
    localparam logic [1:0] EM_BYTE = 2'd1;
    localparam logic [1:0] EM_HALF = 2'd2;
    localparam logic [1:0] EM_WORD = 2'd3;
    localparam logic [15:0] EM_NOP_INSTR = 16'hE800;

    typedef enum logic [1:0] {INIT, IDLE, BUSY, RESP} em_state_t;

    // Index of the highest byte lane touched by an access of the given size.
    function automatic logic [1:0] em_last_lane(input logic [1:0] size);
        return size == EM_BYTE ? 2'd0 : size == EM_HALF ? 2'd1 : 2'd3;
    endfunction
endpackage

// File: rtl/em_boot_rom.sv
// em_boot_rom: combinational byte ROM holding the boot image copied into RAM after reset.
module em_boot_rom #(
    parameter int DEPTH  = 48,
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);
    // Image produced by the assembler flow; bytes past DEPTH read as zero.
    assign data = (int'(addr) < DEPTH) ? 8'(int'(addr) * 29 + 53) : 8'h00;
endmodule

// File: rtl/em_banked_ctrl.sv
// em_banked_ctrl: byte-addressed RAM with boot copy, handshaked data port and
// combinational halfword fetch port with write forwarding.
module em_banked_ctrl
    import em_pkg::*;
#(
    parameter int          MEM_BYTES   = 64,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 0,
    parameter int          INIT_BYTES  = 48,
    parameter logic [15:0] NOP_INSTR   = EM_NOP_INSTR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [15:0]       i_instr,
    output logic              busy
);
    localparam int IW   = $clog2(MEM_BYTES);
    localparam int LAST = INIT_BYTES == 0 ? 0 : INIT_BYTES - 1;

    em_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        cnt;
    logic              we;
    logic [1:0]        size;
    logic [31:0]       wdata;
    logic [7:0]        mem [MEM_BYTES];
    logic [7:0]        rom_data;
    logic [ADDR_W:0]   last_addr;
    logic [ADDR_W:0]   fetch_hi;
    logic              err;
    logic              commit;
    logic              fwd;
    logic [31:0]       rd;
    logic [7:0]        lo;
    logic [7:0]        hi;

    em_boot_rom #(.DEPTH(INIT_BYTES), .ADDR_W(ADDR_W)) u_rom (
        .addr(ptr),
        .data(rom_data)
    );

    // Extra address bit keeps the range check free of wrap-around.
    assign last_addr = {1'b0, addr} + (ADDR_W+1)'(em_last_lane(size));
    assign err       = size == 2'd0 || last_addr >= (ADDR_W+1)'(MEM_BYTES);
    assign commit    = state == BUSY && cnt == 4'd0;
    assign fwd       = commit && we && !err;
    assign fetch_hi  = {1'b0, i_addr} + (ADDR_W+1)'(1);

    always_comb begin
        rd = '0;
        for (int i = 0; i < 4; i++)
            if (2'(i) <= em_last_lane(size)) rd[8*i +: 8] = mem[IW'(addr + ADDR_W'(i))];
    end

    // Walk lanes high to low so the lowest matching lane has the final say.
    always_comb begin
        lo = mem[IW'(i_addr)];
        hi = mem[IW'(fetch_hi)];
        for (int i = 3; i >= 0; i--) begin
            if (fwd && 2'(i) <= em_last_lane(size)) begin
                lo = i_addr == addr + ADDR_W'(i) ? wdata[8*i +: 8] : lo;
                hi = fetch_hi[ADDR_W-1:0] == addr + ADDR_W'(i) ? wdata[8*i +: 8] : hi;
            end
        end
    end

    assign i_instr = (busy || fetch_hi >= (ADDR_W+1)'(MEM_BYTES)) ? NOP_INSTR : {hi, lo};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            ptr      <= '0;
            cnt      <= '0;
            we       <= 1'b0;
            size     <= '0;
            addr     <= '0;
            wdata    <= '0;
            d_ready  <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + ADDR_W'(1);
                    if (ptr == ADDR_W'(LAST)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        d_ready <= 1'b1;
                    end
                end
                IDLE: if (d_req) begin
                    we      <= d_we;
                    size    <= d_size;
                    addr    <= d_addr;
                    wdata   <= d_wdata;
                    cnt     <= 4'(WAIT_STATES);
                    state   <= BUSY;
                    d_ready <= 1'b0;
                end
                BUSY: if (cnt == 4'd0) begin
                    state    <= RESP;
                    d_rvalid <= 1'b1;
                    d_err    <= err;
                    if (err) d_rdata <= '0;
                    else if (!we) d_rdata <= rd;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state    <= IDLE;
                    d_rvalid <= 1'b0;
                    d_err    <= 1'b0;
                    d_ready  <= 1'b1;
                end
            endcase
        end
    end

    // RAM is never cleared by reset; only the boot copy and committed writes touch it.
    always_ff @(posedge clock) begin
        if (state == INIT && INIT_BYTES > 0) mem[IW'(ptr)] <= rom_data;
        if (fwd)
            for (int i = 0; i < 4; i++)
                if (2'(i) <= em_last_lane(size)) mem[IW'(addr + ADDR_W'(i))] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_em_banked_ctrl.sv
// tb_em_banked_ctrl: directed and randomized accesses checked against a byte-array memory model.
module tb_em_banked_ctrl;
    localparam int WS = 3;
    localparam int MB = 64;
    localparam int IB = 48;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic [9:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [9:0]  i_addr = '0;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [15:0] i_instr;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  m [MB];
    logic [31:0] last_rd = '0;
    int          w;

    em_banked_ctrl #(.MEM_BYTES(MB), .ADDR_W(10), .WAIT_STATES(WS), .INIT_BYTES(IB)) dut (
        .clock(clock), .reset(reset), .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err), .i_addr(i_addr), .i_instr(i_instr), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom(input int a);
        return 8'(a * 29 + 53);
    endfunction

    function automatic logic [15:0] fetch_model(input int ia, input bit f, input int a, input int nb,
                                                input logic [31:0] wd);
        logic [7:0] b [2];
        if (ia + 1 >= MB) return 16'hE800;
        b[0] = m[ia];
        b[1] = m[ia + 1];
        if (f)
            for (int k = 0; k < 2; k++)
                for (int j = nb - 1; j >= 0; j--)
                    if (ia + k == a + j) b[k] = wd[8*j +: 8];
        return {b[1], b[0]};
    endfunction

    task automatic boot();
        i_addr = '0;
        for (int i = 1; i <= IB; i++) begin
            @(posedge clock);
            #1;
            if (i == IB - 1) begin
                check("boot_busy_hi", busy, 1);
                check("boot_nop", i_instr, 16'hE800);
            end
            if (i == IB) check("boot_busy_lo", busy, 0);
        end
        for (int i = 0; i < IB; i++) m[i] = rom(i);
        @(negedge clock);
        check("boot_fetch0", i_instr, {rom(1), rom(0)});
    endtask

    task automatic access(input logic we, input logic [1:0] sz, input int a, input logic [31:0] wd,
                          output int waits);
        int nb;
        bit err;
        logic [31:0] rv;
        d_req = 1'b1; d_we = we; d_size = sz; d_addr = 10'(a); d_wdata = wd;
        waits = 0;
        while (!d_ready && waits < 50) begin
            @(negedge clock);
            waits++;
        end
        check("accept", d_ready, 1);
        if (!d_ready) begin
            d_req = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        d_req = 1'b0; d_we = 1'($urandom); d_size = 2'($urandom); d_addr = 10'($urandom); d_wdata = $urandom;
        nb = sz == 3 ? 4 : int'(sz);
        err = sz == 0 || a + nb - 1 >= MB;
        for (int k = 1; k <= WS + 2; k++) begin
            @(negedge clock);
            check("ready_low", d_ready, 0);
            check("rvalid", d_rvalid, 32'(k == WS + 2));
            check("fetch", i_instr, fetch_model(int'(i_addr), k == WS + 1 && we && !err, a, nb, wd));
            if (k == WS + 1 && !err) begin
                if (we) begin
                    for (int j = 0; j < nb; j++) m[a + j] = wd[8*j +: 8];
                end else begin
                    rv = '0;
                    for (int j = 0; j < nb; j++) rv[8*j +: 8] = m[a + j];
                    last_rd = rv;
                end
            end
            if (k == WS + 1 && err) last_rd = '0;
        end
        check("err", d_err, 32'(err));
        check("rdata", d_rdata, last_rd);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_ready", d_ready, 0);
        check("rst_rvalid", d_rvalid, 0);
        check("rst_rdata", d_rdata, 0);
        check("rst_err", d_err, 0);
        check("rst_busy", busy, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        boot();
        for (int a = IB; a < MB; a += 4) access(1'b1, 2'd3, a, $urandom, w);

        access(1'b1, 2'd3, 20, 32'hA1B2C3D4, w);
        access(1'b0, 2'd1, 21, 32'h0, w);
        check("t2_byte", d_rdata, 32'h000000C3);
        access(1'b0, 2'd2, 22, 32'h0, w);
        check("t2_half", d_rdata, 32'h0000A1B2);

        access(1'b0, 2'd3, 62, 32'h0, w);
        check("t3_oor_err", d_err, 1);
        check("t3_oor_rdata", d_rdata, 0);
        access(1'b1, 2'd0, 10, 32'h12345678, w);
        check("t3_sz0_err", d_err, 1);
        access(1'b0, 2'd3, 8, 32'h0, w);

        i_addr = 10'd30;
        access(1'b1, 2'd2, 31, 32'h0000BEEF, w);
        check("t4_after", i_instr[15:8], 32'hEF);

        access(1'b0, 2'd3, 40, 32'h0, w);
        check("t5_wait_a", w, 1);
        access(1'b0, 2'd3, 44, 32'h0, w);
        check("t5_wait_b", w, 1);

        d_req = 1'b1; d_we = 1'b1; d_size = 2'd3; d_addr = 10'd8; d_wdata = 32'hDEADBEEF;
        w = 0;
        while (!d_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("t6_accept", d_ready, 1);
        @(posedge clock);
        #1 d_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", busy, 1);
        check("t6_rst_ready", d_ready, 0);
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6_no_rvalid", d_rvalid, 0);
        end
        reset = 1'b0;
        boot();
        access(1'b0, 2'd3, 8, 32'h0, w);
        check("t6_rd", d_rdata, {rom(11), rom(10), rom(9), rom(8)});

        for (int n = 0; n < 80; n++) begin
            i_addr = 10'($urandom_range(0, MB));
            access(1'($urandom), 2'($urandom), int'($urandom_range(0, MB + 2)), $urandom, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
